// File: rtl/data_ram.sv
// Byte-addressable data RAM with load/store extension and optional
// two-cycle split handling of accesses that straddle a word boundary.
package data_ram_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        write_byte     = 2'd0,
        write_halfword = 2'd1,
        write_word     = 2'd2
    } write_width_t;
endpackage

module data_ram
    import data_ram_pkg::*;
#(
    parameter int DEPTH         = 1024,
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [XLEN-1:0]  req_addr,
    input  write_width_t     req_width,
    input  logic             req_unsigned,
    input  logic [XLEN-1:0]  req_wdata,
    output logic             resp_valid,
    output logic [XLEN-1:0]  resp_data,
    output logic             resp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, SECOND} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_mem [DEPTH];

    logic [XLEN-1:0] w_idx;
    logic [XLEN-1:0] w_idx_hi;
    logic [1:0]      w_off;
    logic [3:0]      w_size;
    logic [3:0]      w_mask;
    logic            w_cross;
    logic            w_err;
    logic            w_accept;
    logic [7:0]      w_be;
    logic [63:0]     w_wd;

    logic [AW-1:0]   r_idx_hi;
    logic [1:0]      r_off;
    logic [3:0]      r_be_hi;
    logic [31:0]     r_wd_hi;
    logic            r_write;
    logic            r_uns;
    write_width_t    r_width;
    logic [31:0]     r_lo;

    logic            r_resp_valid;
    logic [31:0]     r_resp_data;
    logic            r_resp_err;

    logic [AW-1:0]   w_mem_idx;
    logic [3:0]      w_mem_be;
    logic [31:0]     w_mem_wd;
    logic [31:0]     w_rd_word;
    logic [31:0]     w_ld_raw;
    write_width_t    w_ld_w;
    logic            w_ld_u;
    logic [31:0]     w_ld_ext;

    function automatic logic [31:0] extend(
        input logic [31:0] d,
        input write_width_t w,
        input logic u
    );
        unique case (w)
            write_byte:     return {{24{~u & d[7]}}, d[7:0]};
            write_halfword: return {{16{~u & d[15]}}, d[15:0]};
            default:        return d;
        endcase
    endfunction

    assign w_idx    = {2'b00, req_addr[XLEN-1:2]};
    assign w_idx_hi = w_idx + 1'b1;
    assign w_off    = req_addr[1:0];

    always_comb begin
        w_size = 4'd4;
        w_mask = 4'b1111;
        unique case (req_width)
            write_byte:     begin w_size = 4'd1; w_mask = 4'b0001; end
            write_halfword: begin w_size = 4'd2; w_mask = 4'b0011; end
            default:        begin w_size = 4'd4; w_mask = 4'b1111; end
        endcase
    end

    assign w_cross  = ({2'b00, w_off} + w_size) > 4'd4;
    assign w_err    = (w_idx >= XLEN'(DEPTH))
                    || (w_cross && (w_idx_hi >= XLEN'(DEPTH)))
                    || (w_cross && !MISALIGNED_EN);
    assign req_ready = (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_be      = {4'b0000, w_mask} << w_off;
    assign w_wd      = {32'h0, req_wdata} << {w_off, 3'b000};

    // Single memory port: low word at acceptance, high word in SECOND
    always_comb begin
        w_mem_idx = w_idx[AW-1:0];
        w_mem_be  = 4'b0000;
        w_mem_wd  = 32'h0;
        if (r_state == SECOND) begin
            w_mem_idx = r_idx_hi;
            if (r_write) begin
                w_mem_be = r_be_hi;
                w_mem_wd = r_wd_hi;
            end
        end else if (w_accept && !w_err && req_write) begin
            w_mem_be = w_be[3:0];
            w_mem_wd = w_wd[31:0];
        end
    end

    assign w_rd_word = r_mem[w_mem_idx];

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (w_mem_be[b]) begin
                r_mem[w_mem_idx][8*b +: 8] <= w_mem_wd[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_ld_raw = w_rd_word >> {w_off, 3'b000};
        w_ld_w   = req_width;
        w_ld_u   = req_unsigned;
        if (r_state == SECOND) begin
            w_ld_raw = (r_lo >> {r_off, 3'b000})
                     | (w_rd_word << (6'd32 - {1'b0, r_off, 3'b000}));
            w_ld_w   = r_width;
            w_ld_u   = r_uns;
        end
        w_ld_ext = extend(w_ld_raw, w_ld_w, w_ld_u);
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept && !w_err && w_cross) w_next = SECOND;
            SECOND:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'h0;
            r_resp_err   <= 1'b0;
            r_idx_hi     <= '0;
            r_off        <= 2'b00;
            r_be_hi      <= 4'b0000;
            r_wd_hi      <= 32'h0;
            r_write      <= 1'b0;
            r_uns        <= 1'b0;
            r_width      <= write_byte;
            r_lo         <= 32'h0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'h0;
            r_resp_err   <= 1'b0;
            if (r_state == SECOND) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= r_write ? 32'h0 : w_ld_ext;
            end else if (w_accept) begin
                if (w_err) begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b1;
                end else if (!w_cross) begin
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= req_write ? 32'h0 : w_ld_ext;
                end else begin
                    r_idx_hi <= w_idx_hi[AW-1:0];
                    r_off    <= w_off;
                    r_be_hi  <= w_be[7:4];
                    r_wd_hi  <= w_wd[63:32];
                    r_write  <= req_write;
                    r_uns    <= req_unsigned;
                    r_width  <= req_width;
                    r_lo     <= w_rd_word;
                end
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_ram.sv
// Directed-vector bench for data_ram: split and error-mode instances
// exercised with hand-computed expectations.
module tb_data_ram;
    import data_ram_pkg::*;

    logic clock;
    logic reset_n;

    logic         a_valid, a_ready, a_write, a_uns, a_rv, a_err;
    logic [31:0]  a_addr, a_wdata, a_rdata;
    write_width_t a_width;

    logic         b_valid, b_ready, b_write, b_uns, b_rv, b_err;
    logic [31:0]  b_addr, b_wdata, b_rdata;
    write_width_t b_width;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] d;
    logic        e;
    int          l;
    logic        r;

    data_ram #(.DEPTH(1024), .MISALIGNED_EN(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(a_valid), .req_ready(a_ready),
        .req_write(a_write), .req_addr(a_addr),
        .req_width(a_width), .req_unsigned(a_uns),
        .req_wdata(a_wdata), .resp_valid(a_rv),
        .resp_data(a_rdata), .resp_err(a_err)
    );

    data_ram #(.DEPTH(1024), .MISALIGNED_EN(1'b0)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(b_valid), .req_ready(b_ready),
        .req_write(b_write), .req_addr(b_addr),
        .req_width(b_width), .req_unsigned(b_uns),
        .req_wdata(b_wdata), .resp_valid(b_rv),
        .resp_data(b_rdata), .resp_err(b_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(
        input string tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(
        input  int           which,
        input  logic         wr,
        input  logic [31:0]  addr,
        input  write_width_t wd,
        input  logic         uns,
        input  logic [31:0]  wdata,
        output logic [31:0]  rdata,
        output logic         err,
        output int           lat,
        output logic         rdy1
    );
        @(negedge clock);
        if (which == 0) begin
            a_valid = 1'b1; a_write = wr; a_addr = addr;
            a_width = wd; a_uns = uns; a_wdata = wdata;
        end else begin
            b_valid = 1'b1; b_write = wr; b_addr = addr;
            b_width = wd; b_uns = uns; b_wdata = wdata;
        end
        @(posedge clock);
        #1;
        rdy1 = (which == 0) ? a_ready : b_ready;
        // scramble request fields so late sampling would be visible
        if (which == 0) begin
            a_valid = 1'b0; a_addr = 32'h4; a_wdata = 32'h0;
            a_width = write_byte;
        end else begin
            b_valid = 1'b0; b_addr = 32'h4; b_wdata = 32'h0;
            b_width = write_byte;
        end
        lat = 1;
        while (!((which == 0) ? a_rv : b_rv) && lat < 5) begin
            @(posedge clock);
            #1;
            lat++;
        end
        rdata = (which == 0) ? a_rdata : b_rdata;
        err   = (which == 0) ? a_err : b_err;
    endtask

    initial begin
        reset_n = 1'b0;
        a_valid = 0; a_write = 0; a_addr = 0; a_uns = 0; a_wdata = 0;
        b_valid = 0; b_write = 0; b_addr = 0; b_uns = 0; b_wdata = 0;
        a_width = write_byte;
        b_width = write_byte;

        #12;
        chk("rst_rv", 32'(a_rv), 32'd0);
        chk("rst_data", a_rdata, 32'h0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_ready", 32'(a_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(a_ready), 32'd1);

        xfer(0, 1, 32'h10, write_word, 0, 32'hDEADBEEF, d, e, l, r);
        chk("st_err", 32'(e), 32'd0);
        chk("st_data", d, 32'h0);
        chk("st_lat", 32'(l), 32'd1);
        xfer(0, 0, 32'h13, write_byte, 0, 0, d, e, l, r);
        chk("lb_s_data", d, 32'hFFFFFFDE);
        chk("lb_s_err", 32'(e), 32'd0);
        chk("lb_s_lat", 32'(l), 32'd1);
        xfer(0, 0, 32'h10, write_byte, 1, 0, d, e, l, r);
        chk("lb_u_data", d, 32'h000000EF);

        xfer(0, 1, 32'h10, write_word, 0, 32'h11223344, d, e, l, r);
        xfer(0, 1, 32'h12, write_halfword, 0, 32'h0000A55A, d, e, l, r);
        xfer(0, 0, 32'h10, write_word, 0, 0, d, e, l, r);
        chk("sh_merge", d, 32'hA55A3344);
        xfer(0, 0, 32'h12, write_halfword, 0, 0, d, e, l, r);
        chk("lh_s", d, 32'hFFFFA55A);

        xfer(0, 1, 32'h1C, write_word, 0, 32'h11111111, d, e, l, r);
        xfer(0, 1, 32'h20, write_word, 0, 32'h22222222, d, e, l, r);
        xfer(0, 1, 32'h1E, write_word, 0, 32'hCAFEF00D, d, e, l, r);
        chk("x_st_ready", 32'(r), 32'd0);
        chk("x_st_lat", 32'(l), 32'd2);
        chk("x_st_err", 32'(e), 32'd0);
        chk("x_st_data", d, 32'h0);
        @(posedge clock);
        #1;
        chk("x_st_single", 32'(a_rv), 32'd0);
        xfer(0, 0, 32'h1E, write_halfword, 1, 0, d, e, l, r);
        chk("x_lhu_1e", d, 32'h0000F00D);
        xfer(0, 0, 32'h1E, write_halfword, 0, 0, d, e, l, r);
        chk("x_lh_1e", d, 32'hFFFFF00D);
        xfer(0, 0, 32'h20, write_halfword, 1, 0, d, e, l, r);
        chk("x_lhu_20", d, 32'h0000CAFE);
        xfer(0, 0, 32'h1C, write_word, 0, 0, d, e, l, r);
        chk("x_w_1c", d, 32'hF00D1111);
        xfer(0, 0, 32'h20, write_word, 0, 0, d, e, l, r);
        chk("x_w_20", d, 32'h2222CAFE);
        xfer(0, 0, 32'h1E, write_word, 0, 0, d, e, l, r);
        chk("x_lw_data", d, 32'hCAFEF00D);
        chk("x_lw_lat", 32'(l), 32'd2);

        xfer(1, 1, 32'h1C, write_word, 0, 32'h11223344, d, e, l, r);
        xfer(1, 1, 32'h20, write_word, 0, 32'h55667788, d, e, l, r);
        xfer(1, 1, 32'h1E, write_word, 0, 32'hCAFEF00D, d, e, l, r);
        chk("m0_err", 32'(e), 32'd1);
        chk("m0_lat", 32'(l), 32'd1);
        chk("m0_data", d, 32'h0);
        xfer(1, 0, 32'h1C, write_word, 0, 0, d, e, l, r);
        chk("m0_1c", d, 32'h11223344);
        xfer(1, 0, 32'h20, write_word, 0, 0, d, e, l, r);
        chk("m0_20", d, 32'h55667788);

        xfer(0, 0, 32'h1000, write_word, 0, 0, d, e, l, r);
        chk("oor_err", 32'(e), 32'd1);
        chk("oor_data", d, 32'h0);
        chk("oor_lat", 32'(l), 32'd1);
        xfer(0, 0, 32'hFFE, write_word, 0, 0, d, e, l, r);
        chk("oor_x_err", 32'(e), 32'd1);
        chk("oor_x_lat", 32'(l), 32'd1);
        xfer(0, 1, 32'hFFC, write_word, 0, 32'h0BADF00D, d, e, l, r);
        chk("last_st_err", 32'(e), 32'd0);
        xfer(0, 0, 32'hFFC, write_word, 0, 0, d, e, l, r);
        chk("last_ld", d, 32'h0BADF00D);

        xfer(0, 1, 32'h30, write_word, 0, 32'h0, d, e, l, r);
        @(negedge clock);
        a_valid = 1; a_write = 1; a_addr = 32'h31;
        a_width = write_byte; a_uns = 0; a_wdata = 32'h5A;
        @(posedge clock);
        #1;
        chk("b2b_st_rv", 32'(a_rv), 32'd1);
        chk("b2b_ready", 32'(a_ready), 32'd1);
        a_write = 0; a_uns = 1;
        @(posedge clock);
        #1;
        chk("b2b_lb", a_rdata, 32'h0000005A);
        a_width = write_word;
        a_addr = 32'h30;
        @(posedge clock);
        #1;
        chk("b2b_lw", a_rdata, 32'h00005A00);
        a_valid = 0;
        @(posedge clock);
        #1;
        chk("b2b_idle_rv", 32'(a_rv), 32'd0);

        xfer(0, 1, 32'h40, write_word, 0, 32'h11111111, d, e, l, r);
        xfer(0, 1, 32'h44, write_word, 0, 32'h22222222, d, e, l, r);
        @(negedge clock);
        a_valid = 1; a_write = 1; a_addr = 32'h42;
        a_width = write_word; a_wdata = 32'hAABBCCDD;
        @(posedge clock);
        #1;
        a_valid = 0;
        chk("rs_second", 32'(a_ready), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rs_rv", 32'(a_rv), 32'd0);
        chk("rs_ready", 32'(a_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("rs_no_resp", 32'(a_rv), 32'd0);
        chk("rs_ready2", 32'(a_ready), 32'd1);
        xfer(0, 0, 32'h44, write_word, 0, 0, d, e, l, r);
        chk("rs_hi_kept", d, 32'h22222222);
        xfer(0, 0, 32'h40, write_word, 0, 0, d, e, l, r);
        chk("rs_lo_part", d, 32'hCCDD1111);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
